ir_tx_scheduler: RTL and testbench

Frame sequencer and two-port arbiter for the IR transmitter. It owns the shared IR carrier-enable line and the tick stream from the low-rate clock divider. It grants one of two requesters at a time and times a pulse-distance frame (start mark, start space, data bits LSB-first, stop mark, inter-frame gap) in divider ticks. It sits between frame sources (e.g. the control FSM and a loopback/test source) and the carrier modulator.

---
 rtl/ir_tx_scheduler.sv | 132 +++++++++++++
 tb/tb_ir_tx_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_tx_scheduler.sv
// ir_tx_scheduler: two-requester round-robin arbiter and pulse-distance frame
// sequencer for the IR transmitter. Phases are timed in divider ticks; the
// carrier enable is registered and follows the mark phases.
`timescale 1ns/1ps
module ir_tx_scheduler #(
    parameter int DATA_BITS   = 8,
    parameter int START_MARK  = 16,
    parameter int START_SPACE = 8,
    parameter int BIT_MARK    = 1,
    parameter int ZERO_SPACE  = 1,
    parameter int ONE_SPACE   = 3,
    parameter int GAP         = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 tick_i,
    input  logic [1:0]           req_i,
    input  logic [DATA_BITS-1:0] data0_i,
    input  logic [DATA_BITS-1:0] data1_i,
    output logic [1:0]           grant_o,
    output logic [1:0]           done_o,
    output logic                 busy_o,
    output logic                 ir_en_o
);

    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [7:0] L_START_MARK  = 8'(START_MARK);
    localparam logic [7:0] L_START_SPACE = 8'(START_SPACE);
    localparam logic [7:0] L_BIT_MARK    = 8'(BIT_MARK);
    localparam logic [7:0] L_ZERO_SPACE  = 8'(ZERO_SPACE);
    localparam logic [7:0] L_ONE_SPACE   = 8'(ONE_SPACE);
    localparam logic [7:0] L_GAP         = 8'(GAP);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_S_MARK  = 3'd1;
    localparam logic [2:0] ST_S_SPACE = 3'd2;
    localparam logic [2:0] ST_B_MARK  = 3'd3;
    localparam logic [2:0] ST_B_SPACE = 3'd4;
    localparam logic [2:0] ST_STOP    = 3'd5;
    localparam logic [2:0] ST_GAP     = 3'd6;

    logic [2:0]           state;
    logic [7:0]           cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [IDX_W-1:0]     bit_idx;
    logic                 rr_pref;    // 1: requester 1 wins a tie
    logic                 win1;
    logic                 phase_end;

    // Round-robin pick and end-of-phase detection (counter never sits at 0 inside a phase).
    always_comb begin
        win1      = req_i[1] & (~req_i[0] | rr_pref);
        phase_end = tick_i && (cnt == 8'd1);
    end

    assign busy_o = (state != ST_IDLE);

    // Frame sequencer: arbitration, phase counter, shift register and registered outputs.
    // NOTE: every state register here uses <=, so all reads in this block see pre-edge values.
    // NOTE: the async reset clears ir_en_o and grant_o at once, so an aborted frame never emits done_o.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            shreg   <= '0;
            bit_idx <= '0;
            rr_pref <= 1'b0;
            grant_o <= '0;
            done_o  <= '0;
            ir_en_o <= 1'b0;
        end else begin
            done_o <= '0;
            if (state != ST_IDLE && tick_i && !phase_end)
                cnt <= cnt - 8'd1;
            case (state)
                ST_IDLE: begin
                    if (|req_i) begin
                        grant_o <= win1 ? 2'b10 : 2'b01;
                        shreg   <= win1 ? data1_i : data0_i;
                        rr_pref <= ~win1;
                        bit_idx <= '0;
                        cnt     <= L_START_MARK;
                        ir_en_o <= 1'b1;
                        state   <= ST_S_MARK;
                    end
                end
                ST_S_MARK: if (phase_end) begin
                    cnt     <= L_START_SPACE;
                    ir_en_o <= 1'b0;
                    state   <= ST_S_SPACE;
                end
                ST_S_SPACE: if (phase_end) begin
                    cnt     <= L_BIT_MARK;
                    ir_en_o <= 1'b1;
                    state   <= ST_B_MARK;
                end
                ST_B_MARK: if (phase_end) begin
                    cnt     <= shreg[0] ? L_ONE_SPACE : L_ZERO_SPACE;
                    ir_en_o <= 1'b0;
                    state   <= ST_B_SPACE;
                end
                ST_B_SPACE: if (phase_end) begin
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx + 1'b1;
                    cnt     <= L_BIT_MARK;
                    ir_en_o <= 1'b1;
                    state   <= (bit_idx == LAST_BIT) ? ST_STOP : ST_B_MARK;
                end
                ST_STOP: if (phase_end) begin
                    cnt     <= L_GAP;
                    ir_en_o <= 1'b0;
                    state   <= ST_GAP;
                end
                ST_GAP: if (phase_end) begin
                    done_o  <= grant_o;
                    grant_o <= '0;
                    cnt     <= '0;
                    state   <= ST_IDLE;
                end
                default: begin
                    grant_o <= '0;
                    ir_en_o <= 1'b0;
                    cnt     <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_tx_scheduler.sv
// Testbench for ir_tx_scheduler: a segment-list frame model compared every
// cycle, plus literal expectations on frame lengths, spaces and grant order.
`timescale 1ns/1ps
module tb_ir_tx_scheduler;

    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_i = 1'b0;
    logic [1:0] req_i = 2'b00;
    logic [7:0] data0_i = 8'h00;
    logic [7:0] data1_i = 8'h00;
    logic [1:0] grant_o, done_o;
    logic       busy_o, ir_en_o;

    int checks = 0;
    int failures = 0;

    ir_tx_scheduler dut (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .tick_i  (tick_i),
        .req_i   (req_i),
        .data0_i (data0_i),
        .data1_i (data1_i),
        .grant_o (grant_o),
        .done_o  (done_o),
        .busy_o  (busy_o),
        .ir_en_o (ir_en_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Divider ticks: one every 3 clocks, free-running and unaligned to grants.
    int tdiv = 0;
    always @(negedge clk_i) begin
        tdiv   = (tdiv == 2) ? 0 : tdiv + 1;
        tick_i = (tdiv == 0);
    end

    // ---------------- behavioural model: a frame is a list of (level, ticks) segments
    typedef struct {
        bit mark;
        int len;
    } seg_t;

    seg_t       segs[$];
    seg_t       cur;
    int         m_rem = 0;
    int         m_win;
    logic [7:0] m_data;
    logic [1:0] m_grant = 2'b00;
    logic [1:0] m_done = 2'b00;
    logic       m_busy = 1'b0;
    logic       m_ir = 1'b0;
    logic       m_pref = 1'b0;

    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            segs.delete();
            m_grant = 2'b00; m_done = 2'b00; m_busy = 1'b0; m_ir = 1'b0;
            m_pref = 1'b0; m_rem = 0;
        end else begin
            m_done = 2'b00;
            if (!m_busy) begin
                if (req_i != 2'b00) begin
                    m_win   = (req_i == 2'b11) ? int'(m_pref) : (req_i[0] ? 0 : 1);
                    m_pref  = (m_win == 0);
                    m_data  = (m_win == 1) ? data1_i : data0_i;
                    m_grant = 2'(1 << m_win);
                    segs.delete();
                    segs.push_back('{1'b1, 16});
                    segs.push_back('{1'b0, 8});
                    for (int i = 0; i < 8; i++) begin
                        segs.push_back('{1'b1, 1});
                        segs.push_back('{1'b0, m_data[i] ? 3 : 1});
                    end
                    segs.push_back('{1'b1, 1});
                    segs.push_back('{1'b0, 10});
                    m_busy = 1'b1;
                    cur = segs.pop_front();
                    m_ir = cur.mark; m_rem = cur.len;
                end
            end else if (tick_i) begin
                m_rem--;
                if (m_rem == 0) begin
                    if (segs.size() == 0) begin
                        m_done = m_grant; m_grant = 2'b00; m_busy = 1'b0; m_ir = 1'b0;
                    end else begin
                        cur = segs.pop_front();
                        m_ir = cur.mark; m_rem = cur.len;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk_i) begin
        check("grant", 32'(grant_o), 32'(m_grant));
        check("done", 32'(done_o), 32'(m_done));
        check("busy", 32'(busy_o), 32'(m_busy));
        check("ir_en", 32'(ir_en_o), 32'(m_ir));
    end

    // ---------------- monitor: per-frame run lengths of ir_en in ticks
    logic       prev_busy = 1'b0;
    logic       prev_ir = 1'b0;
    int         run = 0;
    int         runs[$];
    int         frames = 0;
    int         frame_ticks = 0;
    int         last_frame_ticks = 0;
    logic [1:0] grants[$];
    int         done_cnt0 = 0;
    int         done_cnt1 = 0;

    always @(posedge clk_i) begin
        if (done_o[0]) done_cnt0++;
        if (done_o[1]) done_cnt1++;
        if (busy_o && !prev_busy) begin
            runs.delete();
            run = 0; frame_ticks = 0; prev_ir = ir_en_o;
            frames++;
            grants.push_back(grant_o);
        end
        if (busy_o) begin
            if (ir_en_o !== prev_ir) begin
                runs.push_back(run);
                run = 0; prev_ir = ir_en_o;
            end
            if (tick_i) begin
                run++; frame_ticks++;
            end
        end else if (prev_busy) begin
            runs.push_back(run);
            last_frame_ticks = frame_ticks;
        end
        prev_busy = busy_o;
    end

    task automatic wait_done(input int idx, input bit drop);
        bit seen = 0;
        for (int i = 0; i < 1500 && !seen; i++) begin
            @(negedge clk_i);
            if (done_o[idx]) begin
                seen = 1;
                check("busy_low_at_done", 32'(busy_o), 32'd0);
                if (drop) req_i[idx] = 1'b0;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_runs(input int fr, input int n);
        bit seen = 0;
        for (int i = 0; i < 1500 && !seen; i++) begin
            @(negedge clk_i);
            if (frames == fr && runs.size() >= n) seen = 1;
        end
        if (!seen) check("runs_timeout", 32'd0, 32'd1);
    endtask

    int a5_sp[8] = '{3, 1, 3, 1, 1, 3, 1, 3};
    int saved_done1;
    int fr0;

    initial begin
        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ir_en", 32'(ir_en_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_i);
        check("idle_ignores_ticks", 32'(busy_o), 32'd0);

        // Single request, data 0x00 on requester 0
        data0_i = 8'h00; req_i = 2'b01;
        @(negedge clk_i);
        check("grant_latency", 32'(grant_o), 32'b01);
        check("ir_en_at_grant", 32'(ir_en_o), 32'd1);
        wait_done(0, 1);
        repeat (2) @(negedge clk_i);
        check("frame_00_ticks", 32'(last_frame_ticks), 32'd51);
        check("frame_00_runs", 32'(runs.size()), 32'd20);
        check("frame_00_start_mark", 32'(runs[0]), 32'd16);
        check("frame_00_start_space", 32'(runs[1]), 32'd8);
        check("frame_00_gap", 32'(runs[19]), 32'd10);

        // 0xFF on requester 1
        data1_i = 8'hFF; req_i = 2'b10;
        wait_done(1, 1);
        repeat (2) @(negedge clk_i);
        check("frame_ff_ticks", 32'(last_frame_ticks), 32'd67);
        check("frame_ff_grant", 32'(grants[grants.size()-1]), 32'b10);
        check("frame_ff_space", 32'(runs[5]), 32'd3);

        // Pattern 0xA5 on requester 0
        data0_i = 8'hA5; req_i = 2'b01;
        wait_done(0, 1);
        repeat (2) @(negedge clk_i);
        for (int i = 0; i < 8; i++)
            check($sformatf("a5_space%0d", i), 32'(runs[3 + 2*i]), 32'(a5_sp[i]));

        // Contention from reset: both requesters held high
        rst_n = 1'b0;
        data0_i = 8'h00; data1_i = 8'h00; req_i = 2'b11;
        repeat (2) @(negedge clk_i);
        grants.delete();
        rst_n = 1'b1;
        wait_done(0, 0);
        wait_done(1, 0);
        wait_done(0, 0);
        req_i = 2'b00;
        repeat (2) @(negedge clk_i);
        check("rr_count", 32'(grants.size()), 32'd3);
        if (grants.size() == 3) begin
            check("rr_first", 32'(grants[0]), 32'b01);
            check("rr_second", 32'(grants[1]), 32'b10);
            check("rr_third", 32'(grants[2]), 32'b01);
        end

        // req_i[0] dropped at bit 3; payload changed after the drop
        fr0 = frames;
        data0_i = 8'h3C; req_i = 2'b01;
        wait_runs(fr0 + 1, 8);
        req_i[0] = 1'b0; data0_i = 8'hFF;
        wait_done(0, 1);
        repeat (2) @(negedge clk_i);
        check("drop_frame_ticks", 32'(last_frame_ticks), 32'd59);

        // Reset during B_SPACE of bit 0 (bit 0 = 1, three-tick space)
        fr0 = frames;
        data1_i = 8'h01; req_i = 2'b10;
        wait_runs(fr0 + 1, 3);
        saved_done1 = done_cnt1;
        #1 rst_n = 1'b0;
        #1;
        check("async_ir_en", 32'(ir_en_o), 32'd0);
        check("async_grant", 32'(grant_o), 32'd0);
        check("async_busy", 32'(busy_o), 32'd0);
        data1_i = 8'h00;
        repeat (3) @(negedge clk_i);
        rst_n = 1'b1;
        @(negedge clk_i);
        check("no_done_after_abort", 32'(done_cnt1), 32'(saved_done1));
        check("restart_s_mark", 32'(ir_en_o), 32'd1);
        wait_done(1, 1);
        repeat (2) @(negedge clk_i);
        check("restart_done_count", 32'(done_cnt1), 32'(saved_done1 + 1));
        check("restart_frame_ticks", 32'(last_frame_ticks), 32'd51);
        check("restart_start_mark", 32'(runs[0]), 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
